// File: rtl/circuit_eval_pkg.sv
// Shared types and constants for the circuit_evaluator stimulus/capture stage.
package circuit_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 16;
  localparam int STIM_W      = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, async reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/circuit_evaluator.sv
// Sweeps a 4-input gate network through all 16 vectors and captures its truth table
// and per-vector instability. Optional toggle counter: CIRCUIT_EVAL_TOGGLE_COUNT_EN.
//
// state  | meaning
// IDLE   | waiting for start, results held
// SETTLE | stim applied, waiting SETTLE_CYCLES for network and synchronizer
// SAMPLE | SAMPLES cycles of capture for the current vector
// DONE   | one-cycle done pulse, results valid
module circuit_evaluator
  import circuit_eval_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLES       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [STIM_W-1:0]      stim,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic [NUM_VECTORS-1:0] unstable
`ifdef CIRCUIT_EVAL_TOGGLE_COUNT_EN
  ,
  output logic [15:0]            toggles
`endif
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [STIM_W-1:0] VEC_LAST    = STIM_W'(NUM_VECTORS - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [STIM_W-1:0]      vec;
  logic [NUM_VECTORS-1:0] shadow_tt, shadow_un;
  logic [NUM_VECTORS-1:0] tt_next, un_next;
  logic                   ref_val;
  logic                   out_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (out_s)
  );

  // Next shadow values include the current sample, so results can be published
  // on the same edge that enters DONE.
  always_comb begin
    tt_next = shadow_tt;
    un_next = shadow_un;
    if (state == SAMPLE) begin
      if (cnt == '0) tt_next[vec] = out_s;
      else if (out_s != ref_val) un_next[vec] = 1'b1;
    end
  end

`ifdef CIRCUIT_EVAL_TOGGLE_COUNT_EN
  logic [15:0] tog_cnt, tog_next;
  logic        out_prev;

  always_comb begin
    tog_next = tog_cnt;
    if ((state == SETTLE || state == SAMPLE) && out_s != out_prev && tog_cnt != 16'hFFFF)
      tog_next = tog_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_cnt  <= '0;
      out_prev <= 1'b0;
      toggles  <= '0;
    end else begin
      out_prev <= out_s;
      if (state == IDLE) begin
        if (start) tog_cnt <= '0;
      end else begin
        tog_cnt <= tog_next;
      end
      if (state == SAMPLE && cnt == SAMPLE_LAST && vec == VEC_LAST) toggles <= tog_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      vec         <= '0;
      stim        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ref_val     <= 1'b0;
      shadow_tt   <= '0;
      shadow_un   <= '0;
      truth_table <= '0;
      unstable    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            stim      <= '0;
            cnt       <= '0;
            shadow_tt <= '0;
            shadow_un <= '0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          shadow_tt <= tt_next;
          shadow_un <= un_next;
          if (cnt == '0) ref_val <= out_s;
          if (cnt == SAMPLE_LAST) begin
            cnt <= '0;
            if (vec == VEC_LAST) begin
              truth_table <= tt_next;
              unstable    <= un_next;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              vec   <= vec + STIM_W'(1);
              stim  <= vec + STIM_W'(1);
              state <= SETTLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
